// File: rtl/slc3_mem_ctrl.sv
// slc3_mem_ctrl -- single-port asynchronous SRAM controller for the SLC-3 CPU.
//
// One CPU access at a time: IDLE samples req, SETUP raises chip enable and
// presents the address, ACCESS holds OE (read) or WE (write) low for
// WAIT_CYCLES cycles, DONE pulses ack for one cycle.
//
// Valid/ready contract: req is a level request sampled only in IDLE; a
// request seen while busy=1 is dropped, never queued. ack is a one-cycle
// completion pulse, and rdata is valid while ack=1 and then held until the
// next read completes.
//
// Optional feature: define MEM_IO_MAP_EN to decode the low 16 address bits
// against IO_ADDR. A hit skips the SRAM entirely: reads return Switches and
// writes load the hex_out display register. Without the macro every address
// goes to SRAM and hex_out is tied to 0.
//
// Ports:
//   Clk, Reset                 clock, asynchronous active-low reset
//   req, we, addr, wdata       CPU request (sampled in IDLE)
//   rdata, ack, busy           CPU response / status
//   Switches, hex_out          board I/O (memory-mapped when enabled)
//   CE, OE, WE, UB, LB         SRAM strobes, active-low
//   SRAM_ADDR                  SRAM address
//   Data_to_SRAM, sram_drive   write data and tristate enable
//   Data_from_SRAM             read data from tristate

module slc3_mem_ctrl #(
    parameter int          DATA_W      = 16,
    parameter int          ADDR_W      = 20,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    output logic              busy,
    input  logic [DATA_W-1:0] Switches,
    output logic [DATA_W-1:0] hex_out,
    output logic              CE,
    output logic              OE,
    output logic              WE,
    output logic              UB,
    output logic              LB,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic [DATA_W-1:0] Data_to_SRAM,
    input  logic [DATA_W-1:0] Data_from_SRAM,
    output logic              sram_drive
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t            state, state_nxt;
    logic [3:0]        cnt;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              io_hit;
    logic              io_rd_load;

`ifdef MEM_IO_MAP_EN
    logic [DATA_W-1:0] hex_q;

    assign io_hit = (addr_q[15:0] == IO_ADDR);

    // The display register is written on the SETUP->DONE edge of an I/O write.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            hex_q <= '0;
        end else if (state == SETUP && io_hit && we_q) begin
            hex_q <= wdata_q;
        end
    end

    assign hex_out = hex_q;
`else
    logic unused_io_addr;

    assign io_hit         = 1'b0;
    assign hex_out        = '0;
    assign unused_io_addr = ^IO_ADDR;
`endif

    assign io_rd_load   = (state == SETUP) && io_hit && !we_q;
    assign SRAM_ADDR    = addr_q;
    assign Data_to_SRAM = wdata_q;

    // State register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req) state_nxt = SETUP;
            SETUP:   state_nxt = io_hit ? DONE : ACCESS;
            ACCESS:  if (cnt == 4'd0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes are decoded straight from the state so an asynchronous reset
    // releases them at once. OE and WE only go low in ACCESS and are chosen
    // by we_q, so they can never be low together; the bus is only driven on
    // writes, so it is never driven while OE is low.
    always_comb begin
        CE         = 1'b1;
        OE         = 1'b1;
        WE         = 1'b1;
        sram_drive = 1'b0;
        ack        = 1'b0;
        case (state)
            SETUP: begin
                CE         = io_hit;
                sram_drive = we_q && !io_hit;
            end
            ACCESS: begin
                CE         = 1'b0;
                OE         = we_q;
                WE         = !we_q;
                sram_drive = we_q;
            end
            DONE: begin
                sram_drive = we_q && !io_hit;
                ack        = 1'b1;
            end
            default: ;
        endcase
    end

    assign UB   = CE;
    assign LB   = CE;
    assign busy = (state != IDLE);

    // Request capture, wait counter and read-data latch
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata   <= '0;
        end else begin
            if (state == IDLE && req) begin
                we_q    <= we;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (state == SETUP) begin
                cnt <= 4'(WAIT_CYCLES - 1);
            end else if (state == ACCESS && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (io_rd_load) begin
                rdata <= Switches;
            end else if (state == ACCESS && cnt == 4'd0 && !we_q) begin
                rdata <= Data_from_SRAM;
            end
        end
    end

endmodule

// File: doc/slc3_mem_ctrl.md
SLC3_MEM_CTRL -- requirements
Module: slc3_mem_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning data bus width.
REQ-002 SHALL have parameter ADDR_W, default 20, meaning SRAM address width.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, meaning SRAM strobe-active cycles per access (legal range 1..15).
REQ-004 SHALL have parameter IO_ADDR, default 16'hFFFF, meaning the memory-mapped I/O address (low 16 bits compared).
REQ-005 SHALL have these ports, one per line:
- Clk  in  1  single clock; all state updates on its rising edge
- Reset  in  1  asynchronous, active-low reset
- req  in  1  CPU access request, sampled in IDLE
- we  in  1  1 = write, 0 = read; sampled with req
- addr  in  ADDR_W  access address
- wdata  in  DATA_W  write data
- rdata  out  DATA_W  read data, valid while ack = 1
- ack  out  1  one-cycle completion pulse
- busy  out  1  high in every state except IDLE
- Switches  in  DATA_W  board switch input for I/O reads
- hex_out  out  DATA_W  I/O display register
- CE, OE, WE, UB, LB  out  1 each  SRAM strobes, active-low
- SRAM_ADDR  out  ADDR_W  SRAM address
- Data_to_SRAM  out  DATA_W  write data to tristate
- Data_from_SRAM  in  DATA_W  read data from tristate
- sram_drive  out  1  tristate output enable, 1 = drive Data

Function
REQ-006 SHALL implement FSM states IDLE, SETUP, ACCESS, DONE.
REQ-007 IDLE with req=1 SHALL capture addr, wdata and we into registers and go to SETUP; req=0 SHALL keep it in IDLE.
REQ-008 SETUP SHALL last 1 cycle, assert CE=0, drive SRAM_ADDR from the captured address, and load the wait counter with WAIT_CYCLES-1.
REQ-009 ACCESS SHALL last exactly WAIT_CYCLES cycles, decrementing the counter each cycle and leaving when it reaches 0.
REQ-010 A read SHALL hold OE=0 throughout ACCESS and latch Data_from_SRAM into rdata on the final ACCESS cycle.
REQ-011 A write SHALL hold WE=0 throughout ACCESS and assert sram_drive=1 with Data_to_SRAM=captured wdata from SETUP through DONE.
REQ-012 DONE SHALL last 1 cycle with ack=1, then the FSM SHALL return to IDLE.
REQ-013 ack SHALL rise WAIT_CYCLES+2 cycles after the sampling edge of req.
REQ-014 OE and WE SHALL never be low in the same cycle, and sram_drive SHALL never be 1 while OE=0.
REQ-015 UB and LB SHALL be 0 whenever CE=0, and 1 otherwise.
REQ-016 req asserted while busy=1 SHALL be ignored and not queued.
REQ-017 req held high through DONE SHALL start a new access on the first IDLE cycle that follows.
REQ-018 rdata SHALL hold its last value until the next read completes.
REQ-019 When the FSM is in IDLE, CE, OE and WE SHALL be 1 and sram_drive SHALL be 0.

Reset
REQ-020 Reset=0 SHALL, immediately and without waiting for Clk, force state IDLE, counter 0, rdata 0, hex_out 0, ack 0, busy 0, CE/OE/WE/UB/LB 1, sram_drive 0 and SRAM_ADDR 0.
REQ-021 Reset asserted mid-access SHALL abort the access with no ack and no further SRAM strobe.

Configuration
REQ-022 With macro MEM_IO_MAP_EN defined, an access whose captured address low 16 bits equal IO_ADDR SHALL go SETUP->DONE with no SRAM strobes. The access completes with ack 2 cycles after sampling.
- An I/O read SHALL return Switches.
- An I/O write SHALL load hex_out.
REQ-023 Without MEM_IO_MAP_EN, every address SHALL access SRAM and hex_out SHALL be constant 0.

Verification
REQ-024 Read, WAIT_CYCLES=2: Data_from_SRAM=16'h1234, read addr 20'h00010 -> OE=0 for 2 cycles, ack at cycle 4, rdata=16'h1234.
REQ-025 Write, WAIT_CYCLES=3: wdata=16'hBEEF, addr 20'h00020 -> WE=0 for 3 cycles, Data_to_SRAM=16'hBEEF with sram_drive=1 from SETUP through DONE, ack at cycle 5, OE=1 throughout.
REQ-026 With MEM_IO_MAP_EN: write 16'h00A5 to addr 20'h0FFFF -> hex_out=16'h00A5 and ack at cycle 2 with CE=1 throughout; then a read with Switches=16'h0F0F -> rdata=16'h0F0F.
REQ-027 req pulsed during ACCESS of a prior read -> exactly one ack and no second access.
REQ-028 Reset=0 asserted in the second ACCESS cycle of a write -> WE=1, sram_drive=0 and busy=0 before the next Clk edge, and no ack is issued.
REQ-029 req held high continuously, WAIT_CYCLES=1 -> back-to-back accesses with ack every 4 cycles.
